// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and data memory (slave).
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: LB/LW/SB/SW over the req/ack data bus with a
// stall request while outstanding; every other result passes straight through.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   mem_aluop_i,
  input  logic [4:0]   mem_wa_i,
  input  logic [31:0]  mem_wd_i,
  input  logic         mem_wreg_i,
  input  logic         mem_mreg_i,
  input  logic [31:0]  mem_din_i,
  input  logic         mem_whilo_i,
  input  logic [63:0]  mem_hilo_i,
  mem_stage_if.master  dm,
  output logic [4:0]   mem_wa_o,
  output logic         mem_wreg_o,
  output logic [31:0]  mem_dreg_o,
  output logic         mem_whilo_o,
  output logic [63:0]  mem_hilo_o,
  output logic         mem_2exe_whilo,
  output logic [63:0]  mem_2exe_hilo,
  output logic         stallreq_mem,
  output logic         bus_err_o
);
  localparam logic [7:0] OP_LB = 8'h90;
  localparam logic [7:0] OP_LW = 8'h92;
  localparam logic [7:0] OP_SB = 8'h98;
  localparam logic [7:0] OP_SW = 8'h9A;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic TO_EN = 1'(TIMEOUT != 0);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          req_r, req_s, we_r, we_s, err_r, err_s, byte_r, byte_s;
  logic [3:0]    be_r, be_s;
  logic [1:0]    lane_r, lane_s;
  logic [31:0]   addr_r, addr_s, wdata_r, wdata_s, result_r, result_s;
  logic          stall_s, is_mem_s, is_store_s, is_byte_s;

  // Sign-extended byte of a load word, picked by the address lane.
  function automatic logic [31:0] lb_ext(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return {{24{b[7]}}, b};
  endfunction

  assign is_store_s = (mem_aluop_i == OP_SB) || (mem_aluop_i == OP_SW);
  assign is_byte_s  = (mem_aluop_i == OP_LB) || (mem_aluop_i == OP_SB);
  assign is_mem_s   = is_store_s || (mem_aluop_i == OP_LB) || (mem_aluop_i == OP_LW);

  // State and bus/result registers; async reset drops the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      be_r     <= 4'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      result_r <= 32'd0;
      err_r    <= 1'b0;
      lane_r   <= 2'd0;
      byte_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      req_r    <= req_s;
      we_r     <= we_s;
      be_r     <= be_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      result_r <= result_s;
      err_r    <= err_s;
      lane_r   <= lane_s;
      byte_r   <= byte_s;
    end
  end

  // Next-state, bus launch, ack/timeout handling and stall request.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    req_s    = req_r;
    we_s     = we_r;
    be_s     = be_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    result_s = result_r;
    err_s    = err_r;
    lane_s   = lane_r;
    byte_s   = byte_r;
    stall_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_mem_s) begin
          stall_s = 1'b1;
          state_s = ST_WAIT;
          req_s   = 1'b1;
          we_s    = is_store_s;
          be_s    = is_byte_s ? (4'b0001 << mem_wd_i[1:0]) : 4'b1111;
          addr_s  = {mem_wd_i[31:2], 2'b00};
          wdata_s = (mem_aluop_i == OP_SB) ? {4{mem_din_i[7:0]}} :
                    (is_store_s ? mem_din_i : 32'd0);
          cnt_s   = '0;
          lane_s  = mem_wd_i[1:0];
          byte_s  = is_byte_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (dm.dm_ack) begin
          req_s    = 1'b0;
          state_s  = ST_DONE;
          result_s = we_r ? 32'd0 : (byte_r ? lb_ext(dm.dm_rdata, lane_r) : dm.dm_rdata);
        end else if (TO_EN && (cnt_r == CNT_LAST)) begin
          req_s    = 1'b0;
          state_s  = ST_DONE;
          result_s = 32'd0;
          err_s    = 1'b1;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        err_s   = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        req_s   = 1'b0;
        err_s   = 1'b0;
      end
    endcase
  end

  assign dm.dm_req   = req_r;
  assign dm.dm_we    = we_r;
  assign dm.dm_be    = be_r;
  assign dm.dm_addr  = addr_r;
  assign dm.dm_wdata = wdata_r;

  // Pass-through paths are forced low while reset is held.
  assign mem_wa_o       = rst_n ? mem_wa_i : 5'd0;
  assign mem_wreg_o     = rst_n & mem_wreg_i;
  assign mem_whilo_o    = rst_n & mem_whilo_i;
  assign mem_hilo_o     = rst_n ? mem_hilo_i : 64'd0;
  assign mem_2exe_whilo = rst_n & mem_whilo_i;
  assign mem_2exe_hilo  = rst_n ? mem_hilo_i : 64'd0;
  assign mem_dreg_o     = !rst_n ? 32'd0 :
                          ((state_r == ST_DONE) ? result_r : mem_wd_i);
  assign stallreq_mem   = rst_n & stall_s;
  assign bus_err_o      = err_r;

  logic unused_s;
  assign unused_s = mem_mreg_i;
endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a byte-addressed
// memory model and per-cycle expectations of the stage's handshake.
module tb_mem_stage;
  localparam int TIMEOUT = 16;
  localparam logic [7:0] OP_LB = 8'h90;
  localparam logic [7:0] OP_LW = 8'h92;
  localparam logic [7:0] OP_SB = 8'h98;
  localparam logic [7:0] OP_SW = 8'h9A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mem_aluop_i = 8'd0;
  logic [4:0]  mem_wa_i = 5'd0;
  logic [31:0] mem_wd_i = 32'd0;
  logic        mem_wreg_i = 1'b0;
  logic        mem_mreg_i = 1'b0;
  logic [31:0] mem_din_i = 32'd0;
  logic        mem_whilo_i = 1'b0;
  logic [63:0] mem_hilo_i = 64'd0;
  logic [4:0]  mem_wa_o;
  logic        mem_wreg_o;
  logic [31:0] mem_dreg_o;
  logic        mem_whilo_o;
  logic [63:0] mem_hilo_o;
  logic        mem_2exe_whilo;
  logic [63:0] mem_2exe_hilo;
  logic        stallreq_mem;
  logic        bus_err_o;

  mem_stage_if dm();

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_aluop_i(mem_aluop_i), .mem_wa_i(mem_wa_i), .mem_wd_i(mem_wd_i),
    .mem_wreg_i(mem_wreg_i), .mem_mreg_i(mem_mreg_i), .mem_din_i(mem_din_i),
    .mem_whilo_i(mem_whilo_i), .mem_hilo_i(mem_hilo_i), .dm(dm),
    .mem_wa_o(mem_wa_o), .mem_wreg_o(mem_wreg_o), .mem_dreg_o(mem_dreg_o),
    .mem_whilo_o(mem_whilo_o), .mem_hilo_o(mem_hilo_o),
    .mem_2exe_whilo(mem_2exe_whilo), .mem_2exe_hilo(mem_2exe_hilo),
    .stallreq_mem(stallreq_mem), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] slave_mem [16];
  logic [7:0]  ref_bytes [64];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] w);
    slave_mem[addr[5:2]] = w;
    for (int j = 0; j < 4; j++) ref_bytes[4*int'(addr[5:2]) + j] = w[8*j +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] wd);
    int a;
    int base;
    logic [7:0] b;
    a = int'(wd[5:0]);
    base = a - (a % 4);
    b = ref_bytes[a];
    if (op == OP_LB) return {{24{b[7]}}, b};
    return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
  endfunction

  task automatic ref_store(input logic [7:0] op, input logic [31:0] wd, input logic [31:0] din);
    int a;
    a = int'(wd[5:0]);
    if (op == OP_SB) ref_bytes[a] = din[7:0];
    else for (int j = 0; j < 4; j++) ref_bytes[a - (a % 4) + j] = din[8*j +: 8];
  endtask

  // Starts just after a rising edge; d = WAIT cycle (1-based) carrying ack, 0 = never.
  task automatic run_op(input logic [7:0] op, input logic [31:0] wd, input logic [31:0] din,
                        input logic [4:0] wa, input logic wreg, input logic whilo,
                        input logic [63:0] hilo, input int d);
    bit is_ld, is_st, is_byte;
    logic [3:0] exp_be;
    logic [31:0] exp_wdata, exp_res;
    int idx;
    is_ld = (op == OP_LB) || (op == OP_LW);
    is_st = (op == OP_SB) || (op == OP_SW);
    is_byte = (op == OP_LB) || (op == OP_SB);
    idx = int'(wd[5:2]);
    exp_be = is_byte ? 4'(1 << wd[1:0]) : 4'hF;
    exp_wdata = (op == OP_SB) ? {4{din[7:0]}} : din;
    mem_aluop_i = op; mem_wd_i = wd; mem_din_i = din; mem_wa_i = wa;
    mem_wreg_i = wreg; mem_mreg_i = is_ld; mem_whilo_i = whilo; mem_hilo_i = hilo;
    dm.dm_ack = 1'($urandom_range(0, 1));
    dm.dm_rdata = $urandom;
    @(negedge clk);
    check_eq("wa_o", 64'(mem_wa_o), 64'(wa));
    check_eq("wreg_o", 64'(mem_wreg_o), 64'(wreg));
    check_eq("whilo_o", 64'(mem_whilo_o), 64'(whilo));
    check_eq("hilo_o", mem_hilo_o, hilo);
    check_eq("fwd_whilo", 64'(mem_2exe_whilo), 64'(whilo));
    check_eq("fwd_hilo", mem_2exe_hilo, hilo);
    check_eq("idle_req", 64'(dm.dm_req), 64'd0);
    check_eq("idle_err", 64'(bus_err_o), 64'd0);
    check_eq("idle_stall", 64'(stallreq_mem), 64'(is_ld || is_st));
    if (!(is_ld || is_st)) begin
      check_eq("pass_dreg", 64'(mem_dreg_o), 64'(wd));
      @(posedge clk); #1;
      return;
    end
    exp_res = (d == 0 || is_st) ? 32'd0 : ref_load(op, wd);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(posedge clk); #1;
      dm.dm_ack = (k == d);
      dm.dm_rdata = slave_mem[idx];
      @(negedge clk);
      check_eq("wait_stall", 64'(stallreq_mem), 64'd1);
      check_eq("wait_req", 64'(dm.dm_req), 64'd1);
      check_eq("wait_we", 64'(dm.dm_we), 64'(is_st));
      check_eq("wait_be", 64'(dm.dm_be), 64'(exp_be));
      check_eq("wait_addr", 64'(dm.dm_addr), 64'({wd[31:2], 2'b00}));
      if (is_st) check_eq("wait_wdata", 64'(dm.dm_wdata), 64'(exp_wdata));
      if (k == d) begin
        if (is_st) begin
          for (int j = 0; j < 4; j++)
            if (dm.dm_be[j]) slave_mem[idx][8*j +: 8] = dm.dm_wdata[8*j +: 8];
          ref_store(op, wd, din);
        end
        break;
      end
    end
    @(posedge clk); #1;
    dm.dm_ack = 1'($urandom_range(0, 1));
    dm.dm_rdata = $urandom;
    @(negedge clk);
    check_eq("done_stall", 64'(stallreq_mem), 64'd0);
    check_eq("done_req", 64'(dm.dm_req), 64'd0);
    check_eq("done_err", 64'(bus_err_o), 64'(d == 0));
    if (is_ld || d == 0) check_eq("done_dreg", 64'(mem_dreg_o), 64'(exp_res));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] op;
    int d, kind;
    for (int i = 0; i < 16; i++) poke(32'(i * 4), $urandom);
    dm.dm_ack = 1'b0;
    dm.dm_rdata = 32'd0;
    mem_aluop_i = OP_LW; mem_wd_i = 32'hCAFE_F00D; mem_wa_i = 5'd31;
    mem_wreg_i = 1'b1; mem_whilo_i = 1'b1; mem_hilo_i = 64'hFFFF_0000_1234_5678;
    #12;
    check_eq("rst_req", 64'(dm.dm_req), 64'd0);
    check_eq("rst_addr", 64'(dm.dm_addr), 64'd0);
    check_eq("rst_stall", 64'(stallreq_mem), 64'd0);
    check_eq("rst_dreg", 64'(mem_dreg_o), 64'd0);
    check_eq("rst_wa", 64'(mem_wa_o), 64'd0);
    check_eq("rst_wreg", 64'(mem_wreg_o), 64'd0);
    check_eq("rst_fwd_hilo", mem_2exe_hilo, 64'd0);
    check_eq("rst_fwd_whilo", 64'(mem_2exe_whilo), 64'd0);
    check_eq("rst_err", 64'(bus_err_o), 64'd0);
    mem_aluop_i = 8'd0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h19, 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 64'd0, 1);
    poke(32'h100, 32'hDEAD_BEEF);
    run_op(OP_LW, 32'h100, 32'd0, 5'd3, 1'b1, 1'b0, 64'd0, 1);
    poke(32'h200, 32'h80FF_0011);
    run_op(OP_LB, 32'h203, 32'd0, 5'd4, 1'b1, 1'b0, 64'd0, 1);
    run_op(OP_LB, 32'h201, 32'd0, 5'd4, 1'b1, 1'b0, 64'd0, 2);
    run_op(OP_SB, 32'h302, 32'h1234_56AB, 5'd0, 1'b0, 1'b0, 64'd0, 3);
    run_op(OP_LW, 32'h104, 32'd0, 5'd6, 1'b1, 1'b0, 64'd0, 0);
    run_op(OP_LW, 32'h108, 32'd0, 5'd7, 1'b1, 1'b0, 64'd0, 16);

    mem_aluop_i = OP_LW; mem_wd_i = 32'h40; mem_wa_i = 5'd9; mem_wreg_i = 1'b1;
    dm.dm_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_req", 64'(dm.dm_req), 64'd0);
    check_eq("async_rst_stall", 64'(stallreq_mem), 64'd0);
    mem_aluop_i = 8'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_stall", 64'(stallreq_mem), 64'd0);
    check_eq("post_rst_req", 64'(dm.dm_req), 64'd0);
    @(posedge clk); #1;

    run_op(8'h18, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 64'h1_0000_0002, 1);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        1: op = OP_LB;
        2: op = OP_LW;
        3: op = OP_SB;
        4: op = OP_SW;
        default: begin
          op = 8'($urandom);
          if (op == OP_LB || op == OP_LW || op == OP_SB || op == OP_SW) op = 8'h21;
        end
      endcase
      d = $urandom_range(0, 20);
      if (d > TIMEOUT) d = 0;
      run_op(op, $urandom, $urandom, 5'($urandom), 1'($urandom),
             1'($urandom), {$urandom, $urandom}, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
